// File: rtl/prog_loader_if.sv
// Bundle between the byte-stream program loader and its surroundings:
// the upstream byte handshake, the micro program-memory write port and
// the loader status lines.
interface prog_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [12:0] mem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    // Loader side: consumes bytes, drives memory writes and status.
    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output cpu_reset,
        output done,
        output error
    );

    // Host side: supplies bytes, observes memory writes and status.
    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  cpu_reset,
        input  done,
        input  error
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: receives a framed byte stream
//   HEADER, N, {HI, LO} x N, CHECKSUM
// and writes N 13-bit instruction words into the micro program memory,
// holding the micro in reset until a frame with a matching checksum lands.
module prog_loader #(
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic         clk,
    input  logic         reset,
    prog_loader_if.slave bus
);

    // WRITE is the single cycle in which mem_we is high; the loader
    // stalls the byte stream during it.
    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        HI,
        LO,
        WRITE,
        CSUM,
        DONE,
        ERR
    } state_t;

    state_t      state_reg, state_next;
    logic [8:0]  count_reg, count_next;     // remaining words, 1..256
    logic [7:0]  csum_reg, csum_next;
    logic [7:0]  addr_reg, addr_next;
    logic [12:0] wdata_reg, wdata_next;
    logic        we_reg, we_next;
    logic        cpu_reset_reg, cpu_reset_next;
    logic        done_reg, done_next;
    logic        error_reg, error_next;

    logic        rx_ready;
    logic        accept;

    // Ready is decoded from state only: low just while the write strobe is out.
    always_comb begin
        rx_ready = (state_reg != WRITE);
    end

    assign accept = bus.rx_valid && rx_ready;

    // Next-state and next-output decode; every register holds by default.
    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        csum_next      = csum_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        we_next        = 1'b0;
        cpu_reset_next = cpu_reset_reg;
        done_next      = done_reg;
        error_next     = error_reg;

        case (state_reg)
            IDLE, DONE, ERR: begin
                // Only a header byte opens a frame; anything else is dropped.
                if (accept && bus.rx_data == HEADER) begin
                    state_next     = COUNT;
                    csum_next      = 8'h00;
                    addr_next      = 8'h00;
                    cpu_reset_next = 1'b1;
                    done_next      = 1'b0;
                    error_next     = 1'b0;
                end
            end
            COUNT: begin
                if (accept) begin
                    // A count byte of zero encodes a full 256-word image.
                    count_next = (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
                    csum_next  = csum_reg + bus.rx_data;
                    state_next = HI;
                end
            end
            HI: begin
                if (accept) begin
                    // Upper three bits carry no data but still feed the checksum.
                    wdata_next[12:8] = bus.rx_data[4:0];
                    csum_next        = csum_reg + bus.rx_data;
                    state_next       = LO;
                end
            end
            LO: begin
                if (accept) begin
                    wdata_next[7:0] = bus.rx_data;
                    csum_next       = csum_reg + bus.rx_data;
                    we_next         = 1'b1;
                    state_next      = WRITE;
                end
            end
            WRITE: begin
                // Write strobe is out this cycle; advance to the next slot.
                count_next = count_reg - 9'd1;
                addr_next  = addr_reg + 8'd1;
                state_next = (count_reg == 9'd1) ? CSUM : HI;
            end
            CSUM: begin
                if (accept) begin
                    if (bus.rx_data == csum_reg) begin
                        state_next     = DONE;
                        done_next      = 1'b1;
                        cpu_reset_next = 1'b0;
                    end else begin
                        state_next     = ERR;
                        error_next     = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame or write in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            count_reg     <= 9'd0;
            csum_reg      <= 8'h00;
            addr_reg      <= 8'h00;
            wdata_reg     <= 13'h0000;
            we_reg        <= 1'b0;
            cpu_reset_reg <= 1'b1;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            csum_reg      <= csum_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            we_reg        <= we_next;
            cpu_reset_reg <= cpu_reset_next;
            done_reg      <= done_next;
            error_reg     <= error_next;
        end
    end

    assign bus.rx_ready  = rx_ready;
    assign bus.mem_we    = we_reg;
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = wdata_reg;
    assign bus.cpu_reset = cpu_reset_reg;
    assign bus.done      = done_reg;
    assign bus.error     = error_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames are pushed byte by byte, memory
// writes are logged from the write port, and each scenario task checks
// the log and status lines against hand-computed values.
module tb_prog_loader;

    logic clk;
    logic reset;

    prog_loader_if bus ();

    prog_loader #(.HEADER(8'hA5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_pass;
    int          n_total;
    int          multi_we;
    bit          timeout_seen;
    logic [7:0]  frame_q[$];
    logic [20:0] wr_log[$];
    logic        prev_we;

    // Write monitor: logs every strobed write and flags strobes longer than one cycle.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_log.push_back({bus.mem_addr, bus.mem_wdata});
            if (prev_we === 1'b1) multi_we++;
        end
        prev_we = bus.mem_we;
    end

    // Push frame_q into the loader; optional random idle gaps with junk data.
    task automatic send_frame(input bit gaps);
        int n;
        foreach (frame_q[i]) begin
            if (gaps) begin
                bus.rx_valid = 1'b0;
                bus.rx_data  = 8'hA5;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            bus.rx_data  = frame_q[i];
            bus.rx_valid = 1'b1;
            n = 0;
            while (bus.rx_ready !== 1'b1 && n < 8) begin
                @(negedge clk);
                n++;
            end
            if (n >= 8) timeout_seen = 1'b1;
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic clear_obs();
        wr_log.delete();
        multi_we     = 0;
        timeout_seen = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        n_total++; if (bus.rx_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", bus.rx_ready); else n_pass++;
        n_total++; if (bus.mem_we !== 1'b0) $display("FAIL rst_we: got %b want 0", bus.mem_we); else n_pass++;
        n_total++; if (bus.mem_addr !== 8'h00) $display("FAIL rst_addr: got %h want 00", bus.mem_addr); else n_pass++;
        n_total++; if (bus.mem_wdata !== 13'h0000) $display("FAIL rst_wdata: got %h want 0000", bus.mem_wdata); else n_pass++;
        n_total++; if (bus.cpu_reset !== 1'b1) $display("FAIL rst_cpu_reset: got %b want 1", bus.cpu_reset); else n_pass++;
        n_total++; if (bus.done !== 1'b0 || bus.error !== 1'b0) $display("FAIL rst_status: got done=%b error=%b want 0/0", bus.done, bus.error); else n_pass++;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        $display("test_reset: done");
    endtask

    task automatic test_good_frame();
        clear_obs();
        frame_q = '{8'hA5, 8'h02, 8'h01, 8'h23, 8'h00, 8'h0F, 8'h35};
        send_frame(1'b0);
        repeat (3) @(negedge clk);
        n_total++; if (wr_log.size() !== 2) $display("FAIL good_nwr: got %0d want 2", wr_log.size()); else n_pass++;
        n_total++; if (wr_log.size() < 1 || wr_log[0] !== {8'h00, 13'h0123}) $display("FAIL good_wr0: got %h want %h", (wr_log.size() > 0) ? wr_log[0] : 21'h0, {8'h00, 13'h0123}); else n_pass++;
        n_total++; if (wr_log.size() < 2 || wr_log[1] !== {8'h01, 13'h000F}) $display("FAIL good_wr1: got %h want %h", (wr_log.size() > 1) ? wr_log[1] : 21'h0, {8'h01, 13'h000F}); else n_pass++;
        n_total++; if (multi_we !== 0) $display("FAIL good_we_len: got %0d long strobes want 0", multi_we); else n_pass++;
        n_total++; if (bus.done !== 1'b1) $display("FAIL good_done: got %b want 1", bus.done); else n_pass++;
        n_total++; if (bus.error !== 1'b0) $display("FAIL good_error: got %b want 0", bus.error); else n_pass++;
        n_total++; if (bus.cpu_reset !== 1'b0) $display("FAIL good_cpu_reset: got %b want 0", bus.cpu_reset); else n_pass++;
        n_total++; if (bus.mem_addr !== 8'h02) $display("FAIL good_addr_end: got %h want 02", bus.mem_addr); else n_pass++;
        n_total++; if (timeout_seen !== 1'b0) $display("FAIL good_timeout: got %b want 0", timeout_seen); else n_pass++;
        $display("test_good_frame: %0d writes, done=%b", wr_log.size(), bus.done);
    endtask

    task automatic test_bad_csum();
        clear_obs();
        frame_q = '{8'hA5};
        send_frame(1'b0);
        n_total++; if (bus.cpu_reset !== 1'b1) $display("FAIL reload_cpu_reset: got %b want 1", bus.cpu_reset); else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL reload_done: got %b want 0", bus.done); else n_pass++;
        frame_q = '{8'h02, 8'h01, 8'h23, 8'h00, 8'h0F, 8'h36};
        send_frame(1'b0);
        repeat (3) @(negedge clk);
        n_total++; if (wr_log.size() !== 2) $display("FAIL bad_nwr: got %0d want 2", wr_log.size()); else n_pass++;
        n_total++; if (wr_log.size() < 2 || wr_log[1] !== {8'h01, 13'h000F}) $display("FAIL bad_wr1: got %h want %h", (wr_log.size() > 1) ? wr_log[1] : 21'h0, {8'h01, 13'h000F}); else n_pass++;
        n_total++; if (bus.error !== 1'b1) $display("FAIL bad_error: got %b want 1", bus.error); else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL bad_done: got %b want 0", bus.done); else n_pass++;
        n_total++; if (bus.cpu_reset !== 1'b1) $display("FAIL bad_cpu_reset: got %b want 1", bus.cpu_reset); else n_pass++;
        $display("test_bad_csum: %0d writes, error=%b", wr_log.size(), bus.error);
    endtask

    task automatic test_ignore();
        clear_obs();
        frame_q = '{8'h00, 8'hFF};
        send_frame(1'b0);
        repeat (2) @(negedge clk);
        n_total++; if (wr_log.size() !== 0) $display("FAIL ign_nwr: got %0d want 0", wr_log.size()); else n_pass++;
        n_total++; if (bus.error !== 1'b1) $display("FAIL ign_error_hold: got %b want 1", bus.error); else n_pass++;
        // HI byte E1: only bits [4:0] reach the word; checksum 01+E1+02 = E4.
        frame_q = '{8'hA5, 8'h01, 8'hE1, 8'h02, 8'hE4};
        send_frame(1'b0);
        repeat (3) @(negedge clk);
        n_total++; if (wr_log.size() < 1 || wr_log[0] !== {8'h00, 13'h0102}) $display("FAIL ign_wr0: got %h want %h", (wr_log.size() > 0) ? wr_log[0] : 21'h0, {8'h00, 13'h0102}); else n_pass++;
        n_total++; if (bus.done !== 1'b1 || bus.error !== 1'b0) $display("FAIL ign_status: got done=%b error=%b want 1/0", bus.done, bus.error); else n_pass++;
        $display("test_ignore: %0d writes, done=%b", wr_log.size(), bus.done);
    endtask

    task automatic test_wrap();
        logic [7:0]  csum;
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [12:0] exp_word[256];
        int          bad;
        clear_obs();
        csum = 8'h00;
        frame_q = '{8'hA5, 8'h00};
        for (int i = 0; i < 256; i++) begin
            hi = {i[2:0], i[4:0]};
            lo = ~i[7:0];
            exp_word[i] = {hi[4:0], lo};
            csum = csum + hi + lo;
            frame_q.push_back(hi);
            frame_q.push_back(lo);
        end
        frame_q.push_back(csum);
        send_frame(1'b0);
        repeat (3) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 256 && i < wr_log.size(); i++) begin
            if (wr_log[i] !== {i[7:0], exp_word[i]}) bad++;
        end
        n_total++; if (wr_log.size() !== 256) $display("FAIL wrap_nwr: got %0d want 256", wr_log.size()); else n_pass++;
        n_total++; if (bad !== 0) $display("FAIL wrap_contents: got %0d bad writes want 0", bad); else n_pass++;
        n_total++; if (bus.mem_addr !== 8'h00) $display("FAIL wrap_addr_end: got %h want 00", bus.mem_addr); else n_pass++;
        n_total++; if (bus.done !== 1'b1) $display("FAIL wrap_done: got %b want 1", bus.done); else n_pass++;
        n_total++; if (multi_we !== 0) $display("FAIL wrap_we_len: got %0d long strobes want 0", multi_we); else n_pass++;
        $display("test_wrap: %0d writes, checksum %h, done=%b", wr_log.size(), csum, bus.done);
    endtask

    task automatic test_reset_mid();
        clear_obs();
        frame_q = '{8'hA5, 8'h02, 8'h01, 8'h23, 8'h00};
        send_frame(1'b0);
        reset = 1'b0;
        #1;
        n_total++; if (bus.mem_addr !== 8'h00) $display("FAIL mid_addr: got %h want 00", bus.mem_addr); else n_pass++;
        n_total++; if (bus.mem_wdata !== 13'h0000) $display("FAIL mid_wdata: got %h want 0000", bus.mem_wdata); else n_pass++;
        n_total++; if (bus.cpu_reset !== 1'b1 || bus.done !== 1'b0 || bus.error !== 1'b0) $display("FAIL mid_status: got cpu_reset=%b done=%b error=%b want 1/0/0", bus.cpu_reset, bus.done, bus.error); else n_pass++;
        n_total++; if (bus.rx_ready !== 1'b1) $display("FAIL mid_ready: got %b want 1", bus.rx_ready); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        // Reset landing on the write strobe itself.
        frame_q = '{8'hA5, 8'h01, 8'h01, 8'h23};
        send_frame(1'b0);
        n_total++; if (bus.mem_we !== 1'b1) $display("FAIL wr_strobe_up: got %b want 1", bus.mem_we); else n_pass++;
        reset = 1'b0;
        #1;
        n_total++; if (bus.mem_we !== 1'b0) $display("FAIL wr_abort: got %b want 0", bus.mem_we); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        clear_obs();
        frame_q = '{8'hA5, 8'h02, 8'h01, 8'h23, 8'h00, 8'h0F, 8'h35};
        send_frame(1'b0);
        repeat (3) @(negedge clk);
        n_total++; if (wr_log.size() < 1 || wr_log[0] !== {8'h00, 13'h0123}) $display("FAIL mid_reload_wr0: got %h want %h", (wr_log.size() > 0) ? wr_log[0] : 21'h0, {8'h00, 13'h0123}); else n_pass++;
        n_total++; if (bus.done !== 1'b1) $display("FAIL mid_reload_done: got %b want 1", bus.done); else n_pass++;
        $display("test_reset_mid: reload %0d writes, done=%b", wr_log.size(), bus.done);
    endtask

    task automatic test_gaps();
        clear_obs();
        frame_q = '{8'hA5, 8'h02, 8'h01, 8'h23, 8'h00, 8'h0F, 8'h35};
        send_frame(1'b1);
        repeat (3) @(negedge clk);
        n_total++; if (wr_log.size() !== 2) $display("FAIL gap_nwr: got %0d want 2", wr_log.size()); else n_pass++;
        n_total++; if (wr_log.size() < 2 || wr_log[0] !== {8'h00, 13'h0123} || wr_log[1] !== {8'h01, 13'h000F}) $display("FAIL gap_contents: got %h %h want %h %h", (wr_log.size() > 0) ? wr_log[0] : 21'h0, (wr_log.size() > 1) ? wr_log[1] : 21'h0, {8'h00, 13'h0123}, {8'h01, 13'h000F}); else n_pass++;
        n_total++; if (bus.done !== 1'b1) $display("FAIL gap_done: got %b want 1", bus.done); else n_pass++;
        n_total++; if (timeout_seen !== 1'b0) $display("FAIL gap_timeout: got %b want 0", timeout_seen); else n_pass++;
        $display("test_gaps: %0d writes, done=%b", wr_log.size(), bus.done);
    endtask

    initial begin
        n_pass       = 0;
        n_total      = 0;
        multi_we     = 0;
        timeout_seen = 1'b0;
        reset        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_ignore();
        test_wrap();
        test_reset_mid();
        test_gaps();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global bound so a stuck handshake cannot hang the run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: HEADER, 8'hA5, sync byte that starts a load frame.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; asserting it (0) forces reset state immediately, release synchronous to clk.
REQ-004 rx_data  input  8  byte from upstream serial receiver.
REQ-005 rx_valid  input  1  rx_data valid this cycle; byte accepted when rx_valid && rx_ready at rising edge.
REQ-006 rx_ready  output  1  loader can accept a byte.
REQ-007 mem_we  output  1  one-cycle write strobe to micro program memory.
REQ-008 mem_addr  output  8  program memory address (matches micro 8-bit pc).
REQ-009 mem_wdata  output  13  instruction word (matches micro 13-bit inst).
REQ-010 cpu_reset  output  1  active-high reset driven to micro; high while no valid program loaded.
REQ-011 done  output  1  last frame loaded and checksum matched.
REQ-012 error  output  1  last frame failed checksum.

Function
REQ-013 States: IDLE, COUNT, HI, LO, CSUM, DONE, ERR; one byte consumed per accepted handshake.
REQ-014 rx_ready SHALL be 1 in every state except the single cycle in which mem_we is asserted.
REQ-015 IDLE/DONE/ERR: accepted byte == HEADER -> COUNT, clear checksum, mem_addr <= 0, cpu_reset <= 1, done <= 0, error <= 0; any other byte ignored, state held.
REQ-016 COUNT: accepted byte N latched as instruction count; N=0 means 256; checksum += N; -> HI.
REQ-017 HI: accepted byte bits [4:0] latched as wdata[12:8]; bits [7:5] ignored for data but included in checksum; -> LO.
REQ-018 LO: accepted byte latched as wdata[7:0]; checksum += byte; next cycle mem_we=1 for exactly one cycle with mem_addr/mem_wdata stable and valid.
REQ-019 After the write cycle: remaining count decrements, mem_addr increments (8-bit, wraps 255->0 only after the 256th write); remaining > 0 -> HI, else -> CSUM.
REQ-020 Checksum: 8-bit modulo-256 sum of COUNT byte and all HI/LO bytes; header and checksum bytes excluded.
REQ-021 CSUM: accepted byte == running checksum -> DONE, done=1, cpu_reset=0; mismatch -> ERR, error=1, cpu_reset stays 1.
REQ-022 done and error SHALL never be 1 simultaneously; both hold until next HEADER accepted in DONE/ERR or reset.
REQ-023 cpu_reset SHALL be 1 in every state except DONE; it rises in the same cycle the HEADER is accepted from DONE (reload).
REQ-024 rx_valid low in any state: state, count, checksum held; no timeout.
REQ-025 Memory contents written before an ERR remain; loader makes no attempt to erase them.
REQ-026 All outputs registered except rx_ready, which is decoded from state.

Reset
REQ-027 reset=0 at any time, including mid-frame or during a mem_we cycle: state IDLE, mem_we=0, mem_addr=0, mem_wdata=0, count=0, checksum=0, cpu_reset=1, done=0, error=0, rx_ready=1 (combinational from IDLE).
REQ-028 A write in progress when reset asserts SHALL be aborted (mem_we deasserts asynchronously).

Verification
REQ-029 Bytes A5,02,01,23,00,0F,checksum 35 -> writes addr0=13'h0123, addr1=13'h000F, each one-cycle mem_we; done=1, cpu_reset=0, error=0.
REQ-030 Same frame with checksum 36 -> two writes occur, then error=1, done=0, cpu_reset=1.
REQ-031 Bytes 00,FF,A5 prior to valid frame -> first two ignored, no writes, frame after A5 loads normally.
REQ-032 COUNT=00 with 256 instruction pairs -> addresses 0..255 written in order, mem_addr wraps to 0 after final write, correct checksum gives done=1.
REQ-033 reset pulsed low after HI byte of second instruction -> all outputs at reset values, next A5 frame loads from addr 0.
REQ-034 rx_valid toggled randomly with gaps during a frame, and rx_valid held high during mem_we cycle -> byte not accepted that cycle, identical memory contents and done=1 versus gap-free run.
